// File: rtl/dmem_timer.sv
// dmem_timer
//   Data-memory subsystem sitting behind the core's load/store path. A 16-byte
//   window at TIMER_BASE maps a prescaled timer/compare peripheral; every other
//   address goes to a word-addressed RAM that aliases across the address space.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset (timer state only; RAM is kept)
//   memaddr    byte address from the core; bits [1:0] ignored
//   memwrite   store strobe, committed at the rising clock edge
//   writedata  store data
//   readdata   load data, combinational from memaddr
//   irq        level interrupt = match_flag & ien
//
// Timer register map (offset = memaddr[3:2])
//   0 CTRL    bit0 en, bit1 autoreload, bit2 ien
//   1 COUNT   32-bit counter
//   2 COMPARE 32-bit compare value
//   3 STATUS  bit0 match_flag, write 1 to clear
module dmem_timer #(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] TIMER_BASE  = 32'hFFFF_0000,
  parameter int          PRESCALE    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memaddr,
  input  logic        memwrite,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_COUNT  = 2'd1;
  localparam logic [1:0] OFF_CMP    = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  // Byte-lane bits are not part of a word access.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^memaddr[1:0];

  // Decode
  logic          tsel;
  logic [1:0]    off;
  logic [AW-1:0] ram_idx;

  assign tsel    = (memaddr[31:4] == TIMER_BASE[31:4]);
  assign off     = memaddr[3:2];
  assign ram_idx = memaddr[AW+1:2];

  // RAM: async read, sync write, deliberately not reset.
  logic [31:0] mem_q [DEPTH_WORDS];
  logic        ram_we;

  assign ram_we = memwrite & ~tsel;

  always_ff @(posedge clk) begin
    if (ram_we) mem_q[ram_idx] <= writedata;
  end

  // Timer state
  logic [2:0]    ctrl_q,    ctrl_d;
  logic [31:0]   count_q,   count_d;
  logic [31:0]   compare_q, compare_d;
  logic          flag_q,    flag_d;
  logic [PW-1:0] pre_q,     pre_d;

  logic t_we;
  logic tick;

  assign t_we = memwrite & tsel;
  assign tick = ctrl_q[0] & (pre_q == PRE_MAX);

  always_comb begin
    ctrl_d    = ctrl_q;
    count_d   = count_q;
    compare_d = compare_q;
    flag_d    = flag_q;
    pre_d     = pre_q;

    // Prescaler: free-runs only while enabled.
    if (ctrl_q[0]) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
    end

    // W1C is applied before the tick so a coincident match keeps the flag set.
    if (t_we && off == OFF_STATUS && writedata[0]) begin
      flag_d = 1'b0;
    end

    // Compare against the registered COMPARE, so a same-cycle write to
    // COMPARE only affects later ticks.
    if (tick) begin
      if (count_q == compare_q) begin
        flag_d  = 1'b1;
        count_d = ctrl_q[1] ? 32'd0 : count_q + 32'd1;
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    if (t_we) begin
      case (off)
        OFF_CTRL: begin
          ctrl_d = writedata[2:0];
          pre_d  = '0;
        end
        OFF_COUNT: count_d   = writedata;   // software write beats the tick
        OFF_CMP:   compare_d = writedata;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q    <= 3'b000;
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      flag_q    <= 1'b0;
      pre_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      flag_q    <= flag_d;
      pre_q     <= pre_d;
    end
  end

  // Read mux
  always_comb begin
    readdata = mem_q[ram_idx];
    if (tsel) begin
      case (off)
        OFF_CTRL:  readdata = {29'd0, ctrl_q};
        OFF_COUNT: readdata = count_q;
        OFF_CMP:   readdata = compare_q;
        default:   readdata = {31'd0, flag_q};
      endcase
    end
  end

  assign irq = flag_q & ctrl_q[2];

endmodule

// File: tb/tb_dmem_timer.sv
// tb_dmem_timer
//   Directed bench for dmem_timer (DEPTH_WORDS=64, PRESCALE=4). Inputs are
//   driven 1ns after a rising edge; outputs are read a further 1ns later,
//   well clear of the next edge.
module tb_dmem_timer;

  localparam logic [31:0] T_BASE   = 32'hFFFF_0000;
  localparam logic [31:0] A_CTRL   = T_BASE;
  localparam logic [31:0] A_COUNT  = T_BASE + 32'd4;
  localparam logic [31:0] A_CMP    = T_BASE + 32'd8;
  localparam logic [31:0] A_STATUS = T_BASE + 32'd12;

  logic        clk;
  logic        reset;
  logic [31:0] memaddr;
  logic        memwrite;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int n_tests;
  int n_fail;

  dmem_timer #(
    .DEPTH_WORDS(64),
    .TIMER_BASE (T_BASE),
    .PRESCALE   (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .memaddr  (memaddr),
    .memwrite (memwrite),
    .writedata(writedata),
    .readdata (readdata),
    .irq      (irq)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memaddr   = a;
    writedata = d;
    memwrite  = 1'b1;
    @(posedge clk);
    #1;
    memwrite  = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    memaddr  = a;
    memwrite = 1'b0;
    #1;
    d = readdata;
    check(tag, d, exp);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    memaddr   = 32'd0;
    memwrite  = 1'b0;
    writedata = 32'd0;

    // Reset state
    #12;
    check("rst_irq", {31'd0, irq}, 32'd0);
    chk_rd("rst_ctrl",   A_CTRL,   32'd0);
    chk_rd("rst_count",  A_COUNT,  32'd0);
    chk_rd("rst_cmp",    A_CMP,    32'hFFFF_FFFF);
    chk_rd("rst_status", A_STATUS, 32'd0);
    reset = 1'b0;
    step(1);

    // 1 RAM
    wr(32'h10, 32'h1111_1111);
    memaddr   = 32'h10;
    writedata = 32'hDEAD_BEEF;
    memwrite  = 1'b1;
    #1;
    check("ram_same_cycle_old", readdata, 32'h1111_1111);
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    chk_rd("ram_read_next", 32'h10, 32'hDEAD_BEEF);
    chk_rd("ram_alias", 32'h10 + 32'd256, 32'hDEAD_BEEF);
    wr(32'hFFFE_FFFC, 32'hA5A5_A5A5);            // just below the timer window
    chk_rd("ram_below_window", 32'h0000_00FC, 32'hA5A5_A5A5);
    chk_rd("ram_window_no_hit", A_CMP, 32'hFFFF_FFFF);
    wr(32'h20, 32'h1234_5678);

    // 2 Timer basic: COMPARE=3, en+ien
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'b101);
    for (int i = 1; i <= 3; i++) begin
      step(3);
      chk_rd($sformatf("basic_hold_%0d", i), A_COUNT, i - 1);
      step(1);
      chk_rd($sformatf("basic_count_%0d", i), A_COUNT, i);
      check($sformatf("basic_irq_low_%0d", i), {31'd0, irq}, 32'd0);
    end
    step(3);
    check("basic_irq_pre_match", {31'd0, irq}, 32'd0);
    step(1);
    check("basic_irq_match", {31'd0, irq}, 32'd1);
    chk_rd("basic_status", A_STATUS, 32'd1);
    chk_rd("basic_count_after", A_COUNT, 32'd4);
    wr(A_STATUS, 32'd1);
    check("basic_irq_cleared", {31'd0, irq}, 32'd0);
    chk_rd("basic_status_cleared", A_STATUS, 32'd0);

    // 3 Autoreload, ien=0
    wr(A_CTRL, 32'd0);
    wr(A_COUNT, 32'd0);
    wr(A_CMP, 32'd2);
    wr(A_CTRL, 32'b011);
    for (int i = 0; i < 6; i++) begin
      step(4);
      chk_rd($sformatf("ar_count_%0d", i), A_COUNT, (i % 3 == 2) ? 32'd0 : 32'(i % 3 + 1));
      chk_rd($sformatf("ar_flag_%0d", i), A_STATUS, (i >= 2) ? 32'd1 : 32'd0);
      check($sformatf("ar_irq_%0d", i), {31'd0, irq}, 32'd0);
    end

    // 4a COUNT write on a tick cycle
    wr(A_CTRL, 32'd0);
    wr(A_STATUS, 32'd1);
    wr(A_COUNT, 32'd0);
    wr(A_CMP, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'b001);
    step(3);
    wr(A_COUNT, 32'd100);                        // lands on the tick edge
    chk_rd("coll_count_write", A_COUNT, 32'd100);

    // 4b W1C on the matching tick
    wr(A_CMP, 32'd101);
    step(6);
    chk_rd("coll_flag_before", A_STATUS, 32'd0);
    wr(A_STATUS, 32'd1);                         // same edge as the match tick
    chk_rd("coll_w1c_vs_set", A_STATUS, 32'd1);
    chk_rd("coll_count_102", A_COUNT, 32'd102);
    wr(A_STATUS, 32'd1);
    chk_rd("coll_w1c_plain", A_STATUS, 32'd0);

    // 4c COMPARE write on a tick cycle uses the old COMPARE
    wr(A_CTRL, 32'd0);
    wr(A_COUNT, 32'd7);
    wr(A_CMP, 32'd7);
    wr(A_CTRL, 32'b001);
    step(3);
    wr(A_CMP, 32'd50);
    chk_rd("coll_cmp_old_flag", A_STATUS, 32'd1);
    chk_rd("coll_cmp_count", A_COUNT, 32'd8);
    chk_rd("coll_cmp_new", A_CMP, 32'd50);
    check("coll_cmp_irq_masked", {31'd0, irq}, 32'd0);

    // 5 Wrap, register read masking
    wr(A_CTRL, 32'd0);
    wr(A_STATUS, 32'd1);
    wr(A_COUNT, 32'hFFFF_FFFF);
    wr(A_CMP, 32'd5);
    wr(A_CTRL, 32'b001);
    step(3);
    chk_rd("wrap_hold", A_COUNT, 32'hFFFF_FFFF);
    step(1);
    chk_rd("wrap_count", A_COUNT, 32'd0);
    chk_rd("wrap_no_flag", A_STATUS, 32'd0);
    wr(A_STATUS, 32'hFFFF_FFFE);
    chk_rd("status_upper", A_STATUS, 32'd0);
    wr(A_CTRL, 32'hFFFF_FFF8);
    chk_rd("ctrl_upper", A_CTRL, 32'd0);
    wr(A_CTRL, 32'hFFFF_FFFD);
    chk_rd("ctrl_bits", A_CTRL, 32'd5);

    // 6 Reset mid-count
    wr(A_CTRL, 32'd0);
    wr(A_COUNT, 32'd0);
    wr(A_CMP, 32'd0);
    wr(A_CTRL, 32'b101);
    step(4);
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    chk_rd("pre_rst_count", A_COUNT, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_irq", {31'd0, irq}, 32'd0);
    chk_rd("mid_rst_count", A_COUNT, 32'd0);
    chk_rd("mid_rst_cmp", A_CMP, 32'hFFFF_FFFF);
    chk_rd("mid_rst_ram", 32'h20, 32'h1234_5678);
    @(negedge clk);
    reset = 1'b0;
    step(5);
    chk_rd("post_rst_count", A_COUNT, 32'd0);
    chk_rd("post_rst_ram", 32'h10, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
